// File: rtl/bit_timing2.sv
// CAN bit timing unit: splits each nominal bit into SYNC/TSEG1/TSEG2 on prescaler tq ticks,
// emits transmit/sample points and applies hard sync or SJW-limited resync on falling edges.
module bit_timing2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       Prescale_EN,
    input  logic       rx,
    input  logic [2:0] prop_seg,
    input  logic [2:0] phase_seg1,
    input  logic [2:0] phase_seg2,
    input  logic [1:0] sjw,
    input  logic       hard_sync_en,
    output logic       sample_point,
    output logic       sampled_bit,
    output logic       tx_point,
    output logic [1:0] bit_state
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TSEG1 = 2'b01,
        ST_TSEG2 = 2'b10
    } state_t;

    state_t     state;
    logic [4:0] cnt;
    logic [2:0] ext;
    logic [2:0] shrt;
    logic       edge_pend;
    logic       resync_done;
    logic       rx_q;

    logic [4:0] l1_len;
    logic [2:0] sjw_len;
    logic       fell;
    logic       resync_ok;
    logic [4:0] cnt_inc;
    logic [2:0] ext_new;
    logic [2:0] shrt_new;
    logic       tseg1_end;
    logic       tseg2_end;
    logic       early_sync;

    assign l1_len    = {2'b00, prop_seg} + {2'b00, phase_seg1} + 5'd2;
    assign sjw_len   = {1'b0, sjw} + 3'd1;
    assign fell      = rx_q & ~rx;
    assign resync_ok = edge_pend & ~resync_done & sampled_bit;
    assign cnt_inc   = cnt + 5'd1;
    assign bit_state = state;

    // End checks are written as sums so no subtraction can wrap.
    always_comb begin
        ext_new = ext;
        if (resync_ok)
            ext_new = (cnt_inc < {2'b00, sjw_len}) ? cnt_inc[2:0] : sjw_len;
        shrt_new   = resync_ok ? sjw_len : shrt;
        tseg1_end  = ({1'b0, cnt} == ({1'b0, l1_len} + {3'b000, ext_new} - 6'd1));
        early_sync = resync_ok && ({3'b000, phase_seg2} <= ({1'b0, cnt} + {3'b000, sjw_len}));
        tseg2_end  = (({1'b0, cnt} + {3'b000, shrt_new}) == {3'b000, phase_seg2});
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_SYNC;
            cnt          <= 5'd0;
            ext          <= 3'd0;
            shrt         <= 3'd0;
            edge_pend    <= 1'b0;
            resync_done  <= 1'b0;
            rx_q         <= 1'b1;
            sample_point <= 1'b0;
            tx_point     <= 1'b0;
            sampled_bit  <= 1'b1;
        end else begin
            rx_q         <= rx;
            sample_point <= 1'b0;
            tx_point     <= 1'b0;
            if (!Prescale_EN) begin
                edge_pend <= edge_pend | fell;
            end else begin
                // pending edge is consumed by this tick; a coincident new edge waits for the next
                edge_pend <= fell;
                if (edge_pend && hard_sync_en) begin
                    state       <= ST_TSEG1;
                    cnt         <= 5'd0;
                    ext         <= 3'd0;
                    shrt        <= 3'd0;
                    resync_done <= 1'b1;
                    tx_point    <= 1'b1;
                end else begin
                    case (state)
                        ST_SYNC: begin
                            state       <= ST_TSEG1;
                            cnt         <= 5'd0;
                            ext         <= 3'd0;
                            shrt        <= 3'd0;
                            resync_done <= 1'b0;
                        end
                        ST_TSEG1: begin
                            ext <= ext_new;
                            if (resync_ok)
                                resync_done <= 1'b1;
                            if (tseg1_end) begin
                                state        <= ST_TSEG2;
                                cnt          <= 5'd0;
                                sample_point <= 1'b1;
                                sampled_bit  <= rx_q;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        ST_TSEG2: begin
                            if (resync_ok)
                                resync_done <= 1'b1;
                            if (early_sync) begin
                                // edge tq counts as the SYNC of the next bit
                                state    <= ST_TSEG1;
                                cnt      <= 5'd0;
                                ext      <= 3'd0;
                                tx_point <= 1'b1;
                            end else begin
                                shrt <= shrt_new;
                                if (tseg2_end) begin
                                    state    <= ST_SYNC;
                                    tx_point <= 1'b1;
                                end else begin
                                    cnt <= cnt_inc;
                                end
                            end
                        end
                        default: state <= ST_SYNC;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_timing2.sv
// Testbench for bit_timing2: segment-length reference model checked every clock,
// plus table-driven nominal timing and hand-built sync/resync/reset sequences.
`timescale 1ns/1ps
module tb_bit_timing2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       Prescale_EN = 1'b0;
    logic       rx = 1'b1;
    logic [2:0] prop_seg = 3'd0;
    logic [2:0] phase_seg1 = 3'd0;
    logic [2:0] phase_seg2 = 3'd0;
    logic [1:0] sjw = 2'd0;
    logic       hard_sync_en = 1'b0;
    logic       sample_point;
    logic       sampled_bit;
    logic       tx_point;
    logic [1:0] bit_state;

    int n_pass = 0;
    int n_total = 0;
    int div = 1;
    int dcnt = 0;
    int cyc = 0;
    int t_sp = 0;
    bit rand_tick = 0;
    bit tick_hold = 0;

    // reference model: segment kind, elapsed tq, current segment length in tq
    logic [1:0] m_seg;
    int         m_el;
    int         m_len;
    bit         m_rs, m_pend, m_rxq, m_sb, m_sp, m_tx;

    typedef struct {
        logic [2:0] p;
        logic [2:0] p1;
        logic [2:0] p2;
        logic [1:0] s;
        int         dv;
        int         exp_sp;
        int         exp_bit;
    } nom_t;
    nom_t nom[4];

    bit_timing2 dut (
        .clock(clock), .reset(reset), .Prescale_EN(Prescale_EN), .rx(rx),
        .prop_seg(prop_seg), .phase_seg1(phase_seg1), .phase_seg2(phase_seg2),
        .sjw(sjw), .hard_sync_en(hard_sync_en),
        .sample_point(sample_point), .sampled_bit(sampled_bit),
        .tx_point(tx_point), .bit_state(bit_state)
    );

    always #50 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        int l1, l2, sj;
        bit e, fell, jumped;
        if (!reset) begin
            m_seg = 2'd0; m_el = 0; m_len = 0; m_rs = 0; m_pend = 0;
            m_rxq = 1; m_sb = 1; m_sp = 0; m_tx = 0;
            return;
        end
        l1 = int'(prop_seg) + int'(phase_seg1) + 2;
        l2 = int'(phase_seg2) + 1;
        sj = int'(sjw) + 1;
        fell = m_rxq && !rx;
        m_sp = 0; m_tx = 0; jumped = 0;
        if (!Prescale_EN) begin
            m_pend = m_pend | fell;
        end else begin
            e = m_pend;
            m_pend = fell;
            if (e && hard_sync_en) begin
                m_seg = 2'd1; m_el = 0; m_len = l1; m_rs = 1; m_tx = 1;
            end else if (m_seg == 2'd0) begin
                m_seg = 2'd1; m_el = 0; m_len = l1; m_rs = 0;
            end else if (m_seg == 2'd1) begin
                if (e && !m_rs && m_sb) begin
                    m_len = l1 + ((m_el + 1 < sj) ? m_el + 1 : sj);
                    m_rs = 1;
                end
                if (m_el == m_len - 1) begin
                    m_seg = 2'd2; m_el = 0; m_len = l2; m_sp = 1; m_sb = m_rxq;
                end else m_el++;
            end else begin
                if (e && !m_rs && m_sb) begin
                    m_rs = 1;
                    if (l2 - 1 - m_el <= sj) begin
                        m_seg = 2'd1; m_el = 0; m_len = l1; m_tx = 1; jumped = 1;
                    end else m_len = l2 - sj;
                end
                if (!jumped) begin
                    if (m_el == m_len - 1) begin
                        m_seg = 2'd0; m_el = 0; m_tx = 1;
                    end else m_el++;
                end
            end
        end
        m_rxq = rx;
    endtask

    task automatic step();
        if (tick_hold) Prescale_EN = 1'b0;
        else if (rand_tick) Prescale_EN = ($urandom_range(0, 2) != 0);
        else begin
            Prescale_EN = (dcnt == 0);
            dcnt = (dcnt + 1) % div;
        end
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        if (sample_point) t_sp = cyc;
        check("model", {27'd0, sample_point, tx_point, sampled_bit, bit_state},
              {27'd0, m_sp, m_tx, m_sb, m_seg});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rx = 1'b1;
        step();
        step();
        reset = 1'b1;
        dcnt = 0;
    endtask

    task automatic cfg(input logic [2:0] p, input logic [2:0] p1, input logic [2:0] p2,
                       input logic [1:0] s);
        prop_seg = p; phase_seg1 = p1; phase_seg2 = p2; sjw = s;
    endtask

    task automatic wait_state(input logic [1:0] seg, input int el, input int budget,
                              input string name);
        int n = 0;
        while (!(m_seg == seg && m_el == el) && n < budget) begin
            step();
            n++;
        end
        check({name, "_reached"}, (m_seg == seg && m_el == el), 1);
    endtask

    task automatic wait_pulse(input bit sel_sp, input int budget, input string name,
                              output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(sel_sp ? sample_point : tx_point) && n < budget);
        check({name, "_seen"}, sel_sp ? sample_point : tx_point, 1);
    endtask

    initial begin
        int n1, n2, t0, t1;
        nom[0] = '{3'd1, 3'd2, 3'd2, 2'd0, 2, 12, 18};
        nom[1] = '{3'd0, 3'd0, 3'd0, 2'd0, 1, 3, 4};
        nom[2] = '{3'd7, 3'd7, 3'd7, 2'd3, 1, 17, 25};
        nom[3] = '{3'd3, 3'd2, 3'd4, 2'd1, 3, 24, 39};

        #5 reset = 1'b0;
        step();
        check("reset_outputs", {sample_point, tx_point, sampled_bit, bit_state}, 5'b00100);
        step();
        reset = 1'b1;

        // nominal bit timing, no bus edges
        for (int i = 0; i < 4; i++) begin
            cfg(nom[i].p, nom[i].p1, nom[i].p2, nom[i].s);
            div = nom[i].dv;
            hard_sync_en = 1'b0;
            do_reset();
            wait_pulse(0, 200, "nom_align", n1);
            wait_pulse(1, 200, "nom_sp", n1);
            check("nom_tx2sp", n1, nom[i].exp_sp);
            check("nom_sampled", sampled_bit, 1);
            wait_pulse(0, 200, "nom_tx", n2);
            check("nom_bit_len", n1 + n2, nom[i].exp_bit);
        end
        div = 1;

        // hard sync from TSEG2 cnt=1
        cfg(3'd1, 3'd2, 3'd2, 2'd0);
        hard_sync_en = 1'b1;
        do_reset();
        wait_state(2'd2, 0, 100, "hs_pos");
        rx = 1'b0;
        step();
        step();
        check("hs_tx", tx_point, 1);
        check("hs_state", bit_state, 2'b01);
        wait_pulse(1, 20, "hs_sp", n1);
        check("hs_sp_dist", n1, 5);
        check("hs_sampled", sampled_bit, 0);
        hard_sync_en = 1'b0;
        rx = 1'b1;

        // no ticks: state frozen, edge held until the next tick
        hard_sync_en = 1'b1;
        do_reset();
        wait_state(2'd2, 0, 100, "hold_pos");
        rx = 1'b0;
        tick_hold = 1'b1;
        repeat (20) step();
        check("hold_state", bit_state, 2'b10);
        check("hold_no_tx", tx_point, 0);
        tick_hold = 1'b0;
        step();
        check("hold_hs_tx", tx_point, 1);
        hard_sync_en = 1'b0;
        rx = 1'b1;

        // late edge extends TSEG1; second edge in the same bit ignored
        cfg(3'd1, 3'd2, 3'd2, 2'd1);
        do_reset();
        wait_pulse(0, 100, "late_align", n1);
        t0 = cyc;
        wait_state(2'd1, 2, 50, "late_e1");
        rx = 1'b0;
        wait_state(2'd1, 4, 50, "late_rise");
        rx = 1'b1;
        wait_state(2'd2, 0, 50, "late_e2");
        rx = 1'b0;
        wait_pulse(0, 50, "late_end", n1);
        check("late_sp_dist", t_sp - t0, 8);
        check("late_bit_len", cyc - t0, 11);
        rx = 1'b1;

        // early edge shortens TSEG2, then an edge near the end acts as SYNC
        cfg(3'd0, 3'd0, 3'd7, 2'd1);
        do_reset();
        wait_pulse(0, 100, "early_align", n1);
        t0 = cyc;
        wait_state(2'd2, 0, 50, "early_e1");
        rx = 1'b0;
        step();
        step();
        rx = 1'b1;
        wait_pulse(0, 50, "early_end", n1);
        check("early_short_bit", cyc - t0, 9);
        t1 = cyc;
        wait_state(2'd2, 5, 50, "early_e2");
        rx = 1'b0;
        step();
        step();
        check("early_jump_tx", tx_point, 1);
        check("early_jump_state", bit_state, 2'b01);
        check("early_jump_len", cyc - t1, 10);
        rx = 1'b1;

        // dominant sample blocks resynchronisation
        cfg(3'd1, 3'd2, 3'd2, 2'd3);
        do_reset();
        wait_state(2'd2, 2, 100, "dom_a");
        rx = 1'b0;
        wait_pulse(1, 50, "dom_sp", n1);
        check("dom_sampled", sampled_bit, 0);
        rx = 1'b1;
        wait_pulse(0, 50, "dom_b_end", n1);
        t0 = cyc;
        wait_state(2'd1, 2, 50, "dom_edge");
        rx = 1'b0;
        wait_pulse(0, 50, "dom_c_end", n1);
        check("dom_bit_len", cyc - t0, 9);
        check("dom_sampled2", sampled_bit, 0);
        rx = 1'b1;

        // reset asserted mid-TSEG1 and right after a sample pulse
        cfg(3'd1, 3'd2, 3'd2, 2'd0);
        do_reset();
        wait_state(2'd1, 2, 100, "rst_pos");
        #10 reset = 1'b0;
        #1;
        check("rst_mid_outputs", {sample_point, tx_point, sampled_bit, bit_state}, 5'b00100);
        step();
        step();
        reset = 1'b1;
        step();
        check("rst_first_tick", {tx_point, bit_state}, 3'b001);
        rx = 1'b0;
        wait_pulse(1, 50, "rst_sp", n1);
        check("rst_pre_sampled", sampled_bit, 0);
        #10 reset = 1'b0;
        #1;
        check("rst_at_pulse", {sample_point, tx_point, sampled_bit, bit_state}, 5'b00100);
        rx = 1'b1;
        step();
        reset = 1'b1;

        // randomized episodes against the reference model
        rand_tick = 1'b1;
        for (int ep = 0; ep < 6; ep++) begin
            cfg(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            hard_sync_en = 1'($urandom_range(0, 1));
            do_reset();
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 5) == 0) rx = ~rx;
                if ($urandom_range(0, 99) == 0) hard_sync_en = ~hard_sync_en;
                step();
            end
        end
        rand_tick = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bit_timing2.md
# bit_timing2

Bit timing unit of the CAN controller: consumes the one-clock time-quantum enable `Prescale_EN` from the prescaler and splits each nominal bit into SYNC, TSEG1 and TSEG2. It generates a transmit-point pulse at bit start, a sample-point pulse and sampled bus level, and performs hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant bus edges. It sits between the prescaler and the MAC/bit-stream logic.

## Interface
- Parameters: none.
- `clock`  in  1  system clock (10 MHz)
- `reset`  in  1  asynchronous, active-low reset
- `Prescale_EN`  in  1  one-clock time-quantum tick (tq tick) from prescaler
- `rx`  in  1  bus level, already synchronised; 1 = recessive
- `prop_seg`  in  3  propagation segment, length = value+1 tq
- `phase_seg1`  in  3  phase segment 1, length = value+1 tq
- `phase_seg2`  in  3  phase segment 2, length = value+1 tq
- `sjw`  in  2  resync jump width, value+1 tq
- `hard_sync_en`  in  1  1 = bus idle/SOF expected: edges cause hard sync
- `sample_point`  out  1  one-clock pulse at end of TSEG1
- `sampled_bit`  out  1  rx level captured at sample point
- `tx_point`  out  1  one-clock pulse at start of each bit (entry to SYNC or sync via edge)
- `bit_state`  out  2  00 SYNC, 01 TSEG1, 10 TSEG2

## Operation
- L1 = prop_seg+phase_seg1+2 (2..16 tq); L2 = phase_seg2+1 (1..8); SJW = sjw+1 (1..4). Configuration inputs are static while operating; changes take effect at next SYNC.
- Registers: `state`, tq counter `cnt` (5 bit, max 19), `ext` (0..4), `shrt` (0..4), `edge_pend`, `resync_done`, `rx_q`.
- Edge detect every clock: `rx_q`=1 and `rx`=0 sets `edge_pend`. `edge_pend` is cleared on every tq tick (evaluated, then dropped). Edge arriving in the same clock as a tick is held for the next tick.
- All state changes only on clocks with `Prescale_EN`=1. Per tick, priority top-down:
  - Hard sync: `edge_pend` and `hard_sync_en` → state TSEG1, cnt=0, ext=0, shrt=0, resync_done=1, tx_point pulse.
  - SYNC: → TSEG1, cnt=0, ext=0, shrt=0, resync_done=0. Edge here: ignored (phase error 0).
  - TSEG1, edge, resync_done=0, sampled_bit=1: ext = min(cnt+1, SJW); resync_done=1. Then end check with updated ext.
  - TSEG1 end: cnt == L1-1+ext → TSEG2, cnt=0, sample_point pulse, sampled_bit <= rx_q. Else cnt+1.
  - TSEG2, edge, resync_done=0, sampled_bit=1: r = L2-1-cnt. If r ≤ SJW → TSEG1, cnt=0, ext=0, resync_done=1, tx_point pulse (edge tq acts as SYNC). Else shrt=SJW, resync_done=1, then end check.
  - TSEG2 end: cnt == L2-1-shrt → SYNC, tx_point pulse. Else cnt+1.
- Edges when sampled_bit=0 or resync_done=1 are ignored (only one resync per bit, only after recessive sample).

## Timing
- Reset values: state SYNC, cnt 0, ext 0, shrt 0, edge_pend 0, resync_done 0, rx_q 1; outputs sample_point 0, tx_point 0, sampled_bit 1, bit_state 00.
- All outputs registered; pulses are high exactly one clock, in the clock after the rising edge where the tick was sampled.
- Nominal bit = 1+L1+L2 tq; tx_point to sample_point = 1+L1 tq... measured tick-to-tick: L1+1 ticks from tx_point to sample_point.
- Reset asserted mid-bit: immediate return to reset values, no pulse emitted; first tick after release leaves SYNC.
- No tick: state frozen indefinitely; edge_pend retained.
- cnt never exceeds 19; shrt ≤ L2-1 guaranteed by r > SJW condition.

## Test plan
- Nominal: prop=1, phase1=2, phase2=2, sjw=0, tick every 2 clocks, rx=1 → tx_point every 18 clocks, sample_point 12 clocks after each tx_point, sampled_bit=1.
- Hard sync: hard_sync_en=1, rx 1→0 in TSEG2 cnt=1 → next tick tx_point, bit_state=01, cnt=0; following sample after 5 ticks, sampled_bit=0.
- Late edge: sjw=1, edge during TSEG1 cnt=3 → ext=2, TSEG1 lasts 7 tq, bit 11 tq; second edge same bit ignored.
- Early edge: phase2=7, sjw=1, edge in TSEG2 cnt=1 (r=6) → TSEG2 shortened to 6 tq; edge at cnt=6 (r=1) → immediate TSEG1, tx_point.
- Dominant sample: sampled_bit=0 then edge in TSEG1 → no extension, bit stays 9 tq.
- Reset mid-TSEG1 → all outputs to reset values within the same clock; no stray pulses.
